// File: rtl/tensor_storage_pkg.sv
// Shared types and defaults for the multi-channel tensor storage.
// Locator state encoding, default parameter values and channel index names.
package tensor_storage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W   = 48;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_LAYERS   = 4;
  localparam int DEF_ROWS     = 64;
  localparam int DEF_IDX_W    = 32;

  localparam int CH_INPUT = 0;
  localparam int CH_LABEL = 1;

  // Address width for an index space of n entries, never narrower than one bit.
  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tensor_storage_bank.sv
// One channel of tensor storage: LAYERS*ROWS words, one write port and one
// synchronous read port with one cycle of latency.
// Optional feature macro: READ_FORWARD_EN -- a write that hits the address being
// read in the same cycle is forwarded into the read register; otherwise the read
// returns the word stored before that write.
module storage_bank #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage array write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register: loads on a read request, cleared by reset so outputs start at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
`ifdef READ_FORWARD_EN
      if (we && (waddr == raddr)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem_r[raddr];
      end
`else
      rdata <= mem_r[raddr];
`endif
    end
  end

endmodule

// File: rtl/tensor_storage.sv
// Multi-channel layer/row tensor storage with a streaming row locator.
// The host writes words by (channel, layer, row); the locator streams one layer
// row by row with every channel side by side over a valid/ready handshake.
// Optional feature macro: READ_FORWARD_EN (same-cycle write-to-read forwarding
// inside each storage_bank).
module tensor_storage
  import tensor_storage_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int LAYERS   = DEF_LAYERS,
  parameter int ROWS     = DEF_ROWS,
  parameter int IDX_W    = DEF_IDX_W,
  localparam int CH_AW   = addr_bits(CHANNELS),
  localparam int L_AW    = addr_bits(LAYERS),
  localparam int R_AW    = addr_bits(ROWS)
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic                       wr_en,
  input  logic [CH_AW-1:0]           wr_channel,
  input  logic [IDX_W-1:0]           wr_layer_index,
  input  logic [IDX_W-1:0]           wr_row_index,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_error,
  input  logic                       rd_start,
  input  logic [IDX_W-1:0]           rd_layer_index,
  input  logic [IDX_W-1:0]           rd_row_count,
  input  logic                       locator_reset,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [CHANNELS*DATA_W-1:0] rd_data,
  output logic [R_AW-1:0]            rd_row_index,
  output logic                       rd_last,
  output logic                       busy,
  output logic                       done,
  output logic                       start_error
);

  localparam int AW    = L_AW + R_AW;
  localparam int CNT_W = R_AW + 1;

  state_t           state_r, state_s;
  logic [L_AW-1:0]  layer_r;
  logic [CNT_W-1:0] count_r;
  logic [R_AW-1:0]  row_r;
  logic             wr_error_r, start_error_r;

  logic             wr_ok_s, rd_layer_ok_s, last_s, launch_s, advance_s;
  logic [CNT_W-1:0] count_in_s;
  logic [AW-1:0]    waddr_s, raddr_s;

  assign wr_ok_s = (32'(wr_channel) < 32'(CHANNELS)) &&
                   (wr_layer_index < IDX_W'(LAYERS)) &&
                   (wr_row_index < IDX_W'(ROWS));
  assign rd_layer_ok_s = (rd_layer_index < IDX_W'(LAYERS));
  assign count_in_s = (rd_row_count > IDX_W'(ROWS)) ? CNT_W'(ROWS)
                                                    : rd_row_count[CNT_W-1:0];
  assign last_s    = ({1'b0, row_r} == (count_r - CNT_W'(1)));
  assign launch_s  = (state_r == IDLE) && rd_start && !locator_reset && rd_layer_ok_s;
  assign advance_s = (state_r == HOLD) && rd_ready && !locator_reset && !last_s;
  assign waddr_s   = {wr_layer_index[L_AW-1:0], wr_row_index[R_AW-1:0]};
  assign raddr_s   = {layer_r, row_r};

  // One storage bank per channel; channel c drives its own slice of rd_data.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
    storage_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (LAYERS * ROWS),
      .AW     (AW)
    ) u_bank (
      .clk     (clk_clk),
      .reset_n (reset_reset_n),
      .we      (wr_en && wr_ok_s && (wr_channel == CH_AW'(c))),
      .waddr   (waddr_s),
      .wdata   (wr_data),
      .re      (state_r == FETCH),
      .raddr   (raddr_s),
      .rdata   (rd_data[c*DATA_W +: DATA_W])
    );
  end

  // Locator state register.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; locator_reset overrides everything, including a new start.
  always_comb begin
    state_s = state_r;
    if (locator_reset) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            state_s = (count_in_s == '0) ? DONE : FETCH;
          end else begin
            state_s = IDLE;
          end
        end
        FETCH: state_s = HOLD;
        HOLD: begin
          if (rd_ready) begin
            state_s = last_s ? DONE : FETCH;
          end else begin
            state_s = HOLD;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Stream parameters, row pointer and the one-cycle error pulses.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      layer_r       <= '0;
      count_r       <= '0;
      row_r         <= '0;
      wr_error_r    <= 1'b0;
      start_error_r <= 1'b0;
    end else begin
      wr_error_r    <= wr_en && !wr_ok_s;
      start_error_r <= (state_r == IDLE) && rd_start && !locator_reset && !rd_layer_ok_s;
      if (launch_s) begin
        layer_r <= rd_layer_index[L_AW-1:0];
        count_r <= count_in_s;
        row_r   <= '0;
      end else if (advance_s) begin
        row_r <= row_r + R_AW'(1);
      end
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    rd_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_r)
      IDLE:    busy     = 1'b0;
      FETCH:   busy     = 1'b1;
      HOLD:    rd_valid = 1'b1;
      DONE:    done     = 1'b1;
      default: busy     = 1'b0;
    endcase
  end

  assign rd_last      = rd_valid && last_s;
  assign rd_row_index = row_r;
  assign wr_error     = wr_error_r;
  assign start_error  = start_error_r;

endmodule

// File: tb/tb_tensor_storage.sv
// Self-checking bench for tensor_storage: directed scenarios plus randomized
// writes and streams, checked against an array model of the stored tensors.
module tb_tensor_storage;
  localparam int DATA_W = 48, CHANNELS = 2, LAYERS = 4, ROWS = 64, IDX_W = 32;

  logic                       clk_clk = 1'b0;
  logic                       reset_reset_n;
  logic                       wr_en;
  logic [0:0]                 wr_channel;
  logic [IDX_W-1:0]           wr_layer_index, wr_row_index;
  logic [DATA_W-1:0]          wr_data;
  logic                       wr_error;
  logic                       rd_start;
  logic [IDX_W-1:0]           rd_layer_index, rd_row_count;
  logic                       locator_reset;
  logic                       rd_valid, rd_ready;
  logic [CHANNELS*DATA_W-1:0] rd_data;
  logic [5:0]                 rd_row_index;
  logic                       rd_last, busy, done, start_error;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem_m [CHANNELS][LAYERS][ROWS];
  bit                ovr_on;
  int                ovr_row;
  logic [DATA_W-1:0] ovr_val;

  tensor_storage dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .wr_en          (wr_en),
    .wr_channel     (wr_channel),
    .wr_layer_index (wr_layer_index),
    .wr_row_index   (wr_row_index),
    .wr_data        (wr_data),
    .wr_error       (wr_error),
    .rd_start       (rd_start),
    .rd_layer_index (rd_layer_index),
    .rd_row_count   (rd_row_count),
    .locator_reset  (locator_reset),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .rd_row_index   (rd_row_index),
    .rd_last        (rd_last),
    .busy           (busy),
    .done           (done),
    .start_error    (start_error)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, rd_valid, 0);
    check_val({tag, "_last"}, rd_last, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_wr_error"}, wr_error, 0);
    check_val({tag, "_start_error"}, start_error, 0);
    check_val({tag, "_data"}, rd_data, 0);
    check_val({tag, "_row"}, rd_row_index, 0);
  endtask

  task automatic do_write(input int ch, input int layer, input int row, input logic [DATA_W-1:0] data);
    bit ok;
    ok = (layer < LAYERS) && (row < ROWS);
    wr_en = 1'b1; wr_channel = ch[0]; wr_layer_index = layer; wr_row_index = row; wr_data = data;
    tick();
    wr_en = 1'b0;
    check_val("wr_error", wr_error, !ok);
    if (ok) mem_m[ch][layer][row] = data;
  endtask

  function automatic logic [CHANNELS*DATA_W-1:0] exp_beat(input int layer, input int row);
    logic [DATA_W-1:0] c0;
    c0 = (ovr_on && row == ovr_row) ? ovr_val : mem_m[0][layer][row];
    return {mem_m[1][layer][row], c0};
  endfunction

  // Stream one layer and check every beat; stall_row/abort_row/fwd_row < 0 disable those features.
  task automatic run_stream(input int layer, input int cnt, input int rdy_pct,
                            input int stall_row, input int abort_row, input int fwd_row);
    int exp_n, row_e, beats, dones, done_cyc, stall;
    bit acc, fin, aborted;
    exp_n = (cnt > ROWS) ? ROWS : cnt;
    row_e = 0; beats = 0; dones = 0; done_cyc = -1; stall = 0; fin = 0; aborted = 0;
    ovr_on = 0;
    rd_layer_index = layer; rd_row_count = cnt; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      wr_en = 1'b0;
      if (done) begin
        dones++; done_cyc = cyc; fin = 1;
        check_val("done_no_valid", rd_valid, 0);
      end else begin
        if (rd_valid) begin
          check_val("beat_data", rd_data, exp_beat(layer, row_e));
          check_val("beat_row", rd_row_index, row_e);
          check_val("beat_last", rd_last, (row_e == exp_n - 1));
        end else if (busy && fwd_row == row_e) begin
          ovr_val = mem_m[0][layer][row_e];
          ovr_row = row_e;
`ifndef READ_FORWARD_EN
          ovr_on = 1;
`endif
          mem_m[0][layer][row_e] = 48'hABC;
          wr_en = 1'b1; wr_channel = 1'b0; wr_layer_index = layer; wr_row_index = row_e;
          wr_data = 48'hABC;
          fwd_row = -1;
        end
        if (abort_row >= 0 && rd_valid && row_e == abort_row) begin
          locator_reset = 1'b1; rd_ready = 1'b1;
          tick();
          locator_reset = 1'b0; rd_ready = 1'b0;
          check_val("abort_busy", busy, 0);
          check_val("abort_valid", rd_valid, 0);
          check_val("abort_done", done, 0);
          tick();
          check_val("abort_done_late", done, 0);
          check_val("abort_busy_late", busy, 0);
          fin = 1; aborted = 1;
        end else begin
          if (rd_valid && row_e == stall_row && stall < 5) begin
            rd_ready = 1'b0; stall++;
          end else begin
            rd_ready = ($urandom_range(99) < rdy_pct);
          end
          acc = rd_valid && rd_ready;
          tick();
          if (acc) begin row_e++; beats++; end
        end
      end
    end
    rd_ready = 1'b0; wr_en = 1'b0;
    if (!aborted) begin
      check_val("beat_count", beats, exp_n);
      check_val("done_count", dones, 1);
      if (rdy_pct == 100 && stall_row < 0) check_val("throughput", done_cyc, 2 * exp_n);
      tick();
      check_val("done_pulse_end", done, 0);
      check_val("idle_after_done", busy, 0);
    end
    ovr_on = 0;
  endtask

  initial begin
    reset_reset_n = 1'b0; wr_en = 1'b0; wr_channel = '0; wr_layer_index = '0; wr_row_index = '0;
    wr_data = '0; rd_start = 1'b0; rd_layer_index = '0; rd_row_count = '0; locator_reset = 1'b0;
    rd_ready = 1'b0; ovr_on = 0; ovr_row = -1; ovr_val = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset_reset_n = 1'b1;
    tick();

    // Fill every location so the model is fully defined.
    for (int c = 0; c < CHANNELS; c++)
      for (int l = 0; l < LAYERS; l++)
        for (int r = 0; r < ROWS; r++)
          do_write(c, l, r, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);

    // Basic stream of four rows on layer 1.
    for (int r = 0; r < 4; r++) begin
      do_write(0, 1, r, 48'(r + 1));
      do_write(1, 1, r, 48'(r + 10));
    end
    run_stream(1, 4, 100, -1, -1, -1);

    // Backpressure: five stalled cycles on row 1.
    run_stream(1, 4, 100, 1, -1, -1);

    // Out-of-range write and start, then an empty stream.
    do_write(0, LAYERS, 0, 48'h5A5A);
    tick();
    check_val("wr_error_pulse_end", wr_error, 0);
    do_write(1, 0, ROWS, 48'h1234);
    rd_layer_index = LAYERS; rd_row_count = 3; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check_val("start_error", start_error, 1);
    check_val("start_error_busy", busy, 0);
    tick();
    check_val("start_error_end", start_error, 0);
    run_stream(0, 0, 100, -1, -1, -1);

    // Oversized count is clamped to ROWS; then an aborted stream.
    run_stream(3, 100, 100, -1, -1, -1);
    run_stream(0, 40, 100, -1, 10, -1);

    // Full reset in the middle of a stream keeps the memory contents.
    rd_layer_index = 2; rd_row_count = 20; rd_start = 1'b1;
    tick();
    rd_start = 1'b0; rd_ready = 1'b1;
    repeat (5) tick();
    reset_reset_n = 1'b0; rd_ready = 1'b0;
    tick();
    check_idle_outputs("midreset");
    reset_reset_n = 1'b1;
    tick();
    run_stream(2, 20, 100, -1, -1, -1);

    // Write to the row being fetched.
    run_stream(0, 4, 100, -1, -1, 2);
    run_stream(0, 4, 100, -1, -1, -1);

    // Randomized writes (some out of range) and streams with random backpressure.
    for (int it = 0; it < 12; it++) begin
      for (int w = 0; w < 6; w++)
        do_write($urandom_range(1), $urandom_range(LAYERS), $urandom_range(ROWS + 1),
                 {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
      run_stream($urandom_range(LAYERS - 1), $urandom_range(70), $urandom_range(100, 30), -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
